// File: rtl/ctrl_msg_switch_pkg.sv
// Shared message field layout and id constants for the control message switch.
package ctrl_msg_switch_pkg;

  localparam int MSG_DEST_MSB   = 63;
  localparam int MSG_DEST_LSB   = 56;
  localparam int MSG_HEADER_MSB = 55;
  localparam int MSG_HEADER_LSB = 48;

  localparam logic [7:0] DEST_BROADCAST = 8'hFF;
  localparam logic [7:0] DEST_ROOT      = 8'h00;

  localparam logic [7:0] HEADER_CMD     = 8'h01;
  localparam logic [7:0] HEADER_RESULT  = 8'h10;
  localparam logic [7:0] HEADER_LATENCY = 8'h11;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Even parity over one message word, for callers that protect stored messages.
  function automatic logic msg_parity(input logic [63:0] msg);
    return ^msg;
  endfunction

endpackage

// File: rtl/ctrl_skid_fifo.sv
// Two-entry FIFO buffering one child's return messages; full reflects the pre-pop state.
module ctrl_skid_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_r == 2'd2);
  assign empty    = (count_r == 2'd0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_msg_switch.sv
// Root<->children control message switch: fan-out downstream, round-robin merge upstream.
// Define CTRL_SWITCH_SRC_TAG_EN to overwrite the upstream dest field with the source child id.
module ctrl_msg_switch
  import ctrl_msg_switch_pkg::*;
#(
  parameter int CTRL_FIFO_WIDTH = 64,
  parameter int NUM_CHILDREN    = 4,
  parameter int CHILD_ID_BASE   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CTRL_FIFO_WIDTH-1:0]             down_data,
  input  logic                                   down_valid,
  output logic                                   down_ready,
  output logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] child_data_out,
  output logic [NUM_CHILDREN-1:0]                child_valid_out,
  input  logic [NUM_CHILDREN-1:0]                child_ready_in,
  input  logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] child_data_in,
  input  logic [NUM_CHILDREN-1:0]                child_valid_in,
  output logic [NUM_CHILDREN-1:0]                child_ready_out,
  output logic [CTRL_FIFO_WIDTH-1:0]             up_data,
  output logic                                   up_valid,
  input  logic                                   up_ready,
  output logic [7:0]                             drop_count,
  output logic                                   switch_busy
);

  localparam int W    = CTRL_FIFO_WIDTH;
  localparam int IDXW = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

  logic [W-1:0]            hold_r;
  logic [NUM_CHILDREN-1:0] pend_r;
  logic [7:0]              drop_r;
  logic [7:0]              down_dest;
  logic [NUM_CHILDREN-1:0] dest_mask;
  logic                    dest_ok;
  logic                    accept;

  assign down_dest       = down_data[MSG_DEST_MSB:MSG_DEST_LSB];
  assign down_ready      = ~|(pend_r & ~child_ready_in);
  assign accept          = down_valid & down_ready;
  assign child_valid_out = pend_r;
  assign child_data_out  = {NUM_CHILDREN{hold_r}};
  assign drop_count      = drop_r;

  // Decode the destination of the incoming root message into a delivery mask.
  always_comb begin
    dest_mask = '0;
    dest_ok   = 1'b0;
    if (down_dest == DEST_BROADCAST) begin
      dest_mask = '1;
      dest_ok   = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        if (down_dest == 8'(CHILD_ID_BASE + i)) begin
          dest_mask[i] = 1'b1;
          dest_ok      = 1'b1;
        end else begin
          dest_mask[i] = dest_mask[i];
        end
      end
    end
  end

  // Holding register and per-child pending mask; each child drains its own bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= '0;
      pend_r <= '0;
      drop_r <= 8'h00;
    end else if (accept) begin
      // accept implies every still-pending bit is handshaking now, so overwrite is safe
      hold_r <= down_data;
      pend_r <= dest_mask;
      if (!dest_ok && (drop_r != DROP_MAX)) begin
        drop_r <= drop_r + 8'd1;
      end
    end else begin
      pend_r <= pend_r & ~child_ready_in;
    end
  end

  logic [NUM_CHILDREN-1:0] fifo_full;
  logic [NUM_CHILDREN-1:0] fifo_empty;
  logic [NUM_CHILDREN-1:0] pop_vec;
  logic [W-1:0]            head [NUM_CHILDREN];

  for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_fifo
    ctrl_skid_fifo #(.WIDTH(W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (child_valid_in[g]),
      .push_data (child_data_in[g*W +: W]),
      .pop       (pop_vec[g]),
      .pop_data  (head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  assign child_ready_out = ~fifo_full;

  logic            up_valid_r;
  logic [W-1:0]    up_data_r;
  logic [IDXW-1:0] last_r;
  logic            load;
  logic            grant_any;
  logic [IDXW-1:0] grant_idx;
  int unsigned     cand;
  logic [W-1:0]    up_next;

  assign load = ~up_valid_r | up_ready;

  // Rotate-priority encode starting just after the last granted child.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_r;
    cand      = 0;
    pop_vec   = '0;
    for (int k = 1; k <= NUM_CHILDREN; k++) begin
      cand = (int'(last_r) + k) % NUM_CHILDREN;
      if (!grant_any && !fifo_empty[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDXW'(cand);
      end else begin
        grant_any = grant_any;
      end
    end
    if (load && grant_any) begin
      pop_vec[grant_idx] = 1'b1;
    end else begin
      pop_vec = '0;
    end
`ifdef CTRL_SWITCH_SRC_TAG_EN
    up_next = head[grant_idx];
    up_next[MSG_DEST_MSB:MSG_DEST_LSB] = 8'(CHILD_ID_BASE + int'(grant_idx));
`else
    up_next = head[grant_idx];
`endif
  end

  // Upstream output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_valid_r <= 1'b0;
      up_data_r  <= '0;
      last_r     <= IDXW'(NUM_CHILDREN - 1);
    end else if (load) begin
      up_valid_r <= grant_any;
      if (grant_any) begin
        up_data_r <= up_next;
        last_r    <= grant_idx;
      end
    end
  end

  assign up_valid    = up_valid_r;
  assign up_data     = up_data_r;
  assign switch_busy = (|pend_r) | ~(&fifo_empty) | up_valid_r;

endmodule

// File: doc/ctrl_msg_switch.md
Name: ctrl_msg_switch

Overview:
- Sits between the root controller's FPGA-side port and the NUM_CHILDREN child control links.
- Downstream: fans out root messages to children. Broadcast (dest 8'hFF) goes to every child; unicast goes to one child.
- Upstream: buffers each child's return messages (HEADER_RESULT, latency reports) and merges them round-robin into the single stream the root consumes.
- Lossless in both directions, valid/ready handshake everywhere.

Parameters:
- CTRL_FIFO_WIDTH, 64, message width.
- NUM_CHILDREN, 4, number of child links (1..15).
- CHILD_ID_BASE, 1, dest id of child 0. Child i has id CHILD_ID_BASE+i.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- down_data  in  CTRL_FIFO_WIDTH  message from root.
- down_valid  in  1  root message valid.
- down_ready  out  1  switch can accept a root message.
- child_data_out  out  NUM_CHILDREN*CTRL_FIFO_WIDTH  per-child message, child i at slice i.
- child_valid_out  out  NUM_CHILDREN  per-child valid.
- child_ready_in  in  NUM_CHILDREN  per-child ready.
- child_data_in  in  NUM_CHILDREN*CTRL_FIFO_WIDTH  return message from each child.
- child_valid_in  in  NUM_CHILDREN  return valid.
- child_ready_out  out  NUM_CHILDREN  return ready (skid buffer not full).
- up_data  out  CTRL_FIFO_WIDTH  merged return message to root.
- up_valid  out  1  merged valid.
- up_ready  in  1  root ready.
- drop_count  out  8  saturating count of root messages with invalid dest.
- switch_busy  out  1  any message held anywhere in the switch.

Behaviour:
- Message fields: dest [63:56], header [55:48].

Downstream:
- One holding register plus pending mask P[NUM_CHILDREN-1:0].
- down_ready = ~|(P & ~child_ready_in). New accept allowed in the same cycle the last pending bits drain.
- On down_valid & down_ready, capture the message:
  - dest 8'hFF: P <= all ones.
  - dest in CHILD_ID_BASE..CHILD_ID_BASE+NUM_CHILDREN-1: P <= one-hot.
  - Any other dest (including 8'h00): message dropped, P <= 0, drop_count increments, saturating at 255.
- child_valid_out = P. All children see the same held data.
- Bit i clears on child_valid_out[i] & child_ready_in[i]. Children drain independently. A slow child never blocks others' delivery of the same message.
- Latency: 1 cycle from down handshake to child_valid_out.

Upstream:
- One 2-entry FIFO per child. child_ready_out[i] = ~full.
- Output register: up_data/up_valid. Data held stable while up_valid & ~up_ready.
- Load condition: up_valid==0 or up_ready==1 (a pop and load in the same cycle is allowed).
- On load, the round-robin arbiter grants the first non-empty FIFO after the last-granted index, wrapping from NUM_CHILDREN-1 to 0. That entry is popped and the pointer updated.
- No non-empty FIFO at load time: up_valid <= 0.
- Latency: child handshake at cycle t gives up_valid at t+2 when idle.
- Simultaneous push and pop on a full FIFO is legal; ready reflects the pre-pop full state.
- Full throughput: 1 upstream message/cycle sustained when up_ready stays high.

switch_busy = |P | any FIFO non-empty | up_valid. Combinational.

Reset (any cycle, including mid-transfer):
- P=0, FIFOs empty, up_valid=0, up_data=0, RR pointer=NUM_CHILDREN-1 (so child 0 has first priority), drop_count=0.
- In-flight messages are discarded.
- Outputs at reset: child_valid_out=0, down_ready=1, child_ready_out=all ones, switch_busy=0.

Optional Feature:
- Macro CTRL_SWITCH_SRC_TAG_EN.
- Defined: on load into the output register, the dest field [63:56] of up_data is replaced with the source child id (CHILD_ID_BASE+granted index). Other bits unchanged.
- Undefined: up_data is a bit-exact copy of the child message.

Decomposition:
- Shared package (parameters include): MSG_DEST_MSB/LSB, MSG_HEADER_MSB/LSB, DEST_BROADCAST=8'hFF, DEST_ROOT=8'h00, header constants (HEADER_RESULT etc.).
- Sub-module ctrl_skid_fifo: 2-entry, parameterised width, push/pop/full/empty. Instantiated NUM_CHILDREN times.
- Arbiter is inline logic: a rotate-priority-encode.

Test Plan:
- Broadcast with all children ready: down message dest FF, header 01 at t → child_valid_out=4'b1111 at t+1 for one cycle, all four slices equal, down_ready high throughout.
- Unicast with a stalled neighbour: dest 8'h03 (child 2) while child_ready_in=4'b0000 for 5 cycles → child_valid_out=4'b0100 held 5 cycles with stable data. down_ready=0 until child 2 ready, then next message accepted the same cycle.
- Partial drain: broadcast with child 1 stalled 3 cycles → bits 0,2,3 clear after 1 cycle, bit 1 after 4. A second message is accepted only when bit 1 clears.
- Invalid dest 8'h00 and 8'h09 → no child_valid_out, drop_count=2. With 300 bad messages, drop_count=255.
- Fairness: all 4 children push HEADER_RESULT simultaneously, up_ready=1 → up_data order child0,1,2,3 on consecutive cycles, first at t+2. With CTRL_SWITCH_SRC_TAG_EN, dest fields read 01,02,03,04.
- Backpressure and reset: up_ready=0 with 3 pushes from child 0 → child_ready_out[0] drops after 2 FIFO entries plus 1 in the output register. Reset asserted mid-stall → switch_busy=0, up_valid=0, child_ready_out=4'b1111 next cycle.
